// File: rtl/spu32_wb8_pipelined_ram_pkg.sv
// Shared definitions for the 8-bit pipelined Wishbone RAM responder:
// service FSM states and the layout of one request-queue entry.
package spu32_wb8_pipelined_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } svc_state_e;

    localparam int unsigned WAIT_CNT_W   = 4;
    localparam int unsigned ENT_DATA_LSB = 0;
    localparam int unsigned ENT_DATA_W   = 8;
    localparam int unsigned ENT_ADDR_LSB = ENT_DATA_LSB + ENT_DATA_W;

    // Entry = {we, addr[aw-1:0], data[7:0]}; the write flag sits above the address.
    function automatic int unsigned ent_we_bit(input int unsigned aw);
        return ENT_ADDR_LSB + aw;
    endfunction

    function automatic int unsigned ent_width(input int unsigned aw);
        return 1 + aw + ENT_DATA_W;
    endfunction

endpackage

// File: rtl/spu32_wb8_pipelined_ram_if.sv
// Wishbone B4 pipelined 8-bit bus. cyc/stb/we/adr/dat_w map to CYC_I/STB_I/WE_I/ADR_I/DAT_I,
// dat_r/ack/stall map to DAT_O/ACK_O/STALL_O on the responder side.
interface spu32_wb8_pipelined_ram_if;
    // Handshake: a request transfers at a rising edge where cyc & stb & !stall;
    // each transferred request earns exactly one single-cycle ack, in order.
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [7:0]  dat_w;
    logic [7:0]  dat_r;
    logic        ack;
    logic        stall;

    modport master (
        output cyc, stb, we, adr, dat_w,
        input  dat_r, ack, stall
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w,
        output dat_r, ack, stall
    );
endinterface

// File: rtl/spu32_wb8_reqfifo.sv
// In-order request queue: wrap-around pointers plus a separate occupancy count.
// Flush empties the queue and wins over a push or pop at the same edge.
module spu32_wb8_reqfifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 21
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] slots_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = slots_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o & ~flush_i;
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) slots_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/spu32_wb8_pipelined_ram.sv
// Pipelined 8-bit Wishbone RAM responder: queued requests are served in order,
// each after WAIT_STATES idle cycles, with one ACK per request.
module spu32_wb8_pipelined_ram
    import spu32_wb8_pipelined_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic                           CLK_I,
    input  logic                           RST_I,
    spu32_wb8_pipelined_ram_if.slave       bus,
    output svc_state_e                     state_o
);
    localparam int unsigned EW        = ent_width(ADDR_WIDTH);
    localparam int unsigned WE_BIT    = ent_we_bit(ADDR_WIDTH);
    localparam int unsigned CW        = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned MEM_BYTES = 1 << ADDR_WIDTH;
    localparam logic [WAIT_CNT_W-1:0] WS_L = WAIT_CNT_W'(WAIT_STATES);
    localparam svc_state_e FIRST_ST = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;

    svc_state_e              state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_q, wait_d;
    logic                    ack_q;
    logic [7:0]              dat_q;
    logic [7:0]              mem [MEM_BYTES];

    logic [EW-1:0]           entry_in, head;
    logic [CW-1:0]           count;
    logic                    full, empty;
    logic                    push, exec, busy_next;
    logic                    head_we;
    logic [ADDR_WIDTH-1:0]   head_addr;
    logic [7:0]              head_data;
    logic                    unused_adr;

    assign bus.stall = ~RST_I | full;
    assign push      = bus.cyc & bus.stb & ~bus.stall;
    assign entry_in  = {bus.we, bus.adr[ADDR_WIDTH-1:0], bus.dat_w};
    assign unused_adr = ^{bus.adr, empty};

    assign head_we   = head[WE_BIT];
    assign head_addr = head[ENT_ADDR_LSB +: ADDR_WIDTH];
    assign head_data = head[ENT_DATA_LSB +: ENT_DATA_W];

    // The head executes at an edge where the FSM sits in ACCESS and the cycle is still live.
    assign exec = RST_I & bus.cyc & (state_q == ST_ACCESS);

    // Occupancy after this edge, counting this edge's enqueue and dequeue.
    assign busy_next = push | (count > {{(CW-1){1'b0}}, exec});

    spu32_wb8_reqfifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (EW)
    ) u_reqfifo (
        .clk_i   (CLK_I),
        .rst_ni  (RST_I),
        .push_i  (push),
        .pop_i   (exec),
        .flush_i (~bus.cyc),
        .data_i  (entry_in),
        .head_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            ST_IDLE: begin
                if (busy_next) begin
                    wait_d  = '0;
                    state_d = FIRST_ST;
                end
            end
            ST_WAIT: begin
                wait_d = wait_q + 1'b1;
                if (wait_d == WS_L) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                wait_d  = '0;
                state_d = busy_next ? FIRST_ST : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!bus.cyc) begin
            state_d = ST_IDLE;
            wait_d  = '0;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            ack_q   <= 1'b0;
            dat_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            ack_q   <= exec;
            if (exec && !head_we) dat_q <= mem[head_addr];
        end
    end

    // Memory has no reset so it maps onto a block RAM; contents survive RST_I.
    always_ff @(posedge CLK_I) begin
        if (exec && head_we) mem[head_addr] <= head_data;
    end

    assign bus.ack   = ack_q;
    assign bus.dat_r = dat_q;
    assign state_o   = state_q;
endmodule

// File: tb/tb_spu32_wb8_pipelined_ram.sv
// Bench for spu32_wb8_pipelined_ram: three instances (WAIT_STATES 0, 2, 3) driven one at a time,
// with a timing/data scoreboard fed at accept time and drained on ACK.
module tb_spu32_wb8_pipelined_ram;
    import spu32_wb8_pipelined_ram_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    logic [2:0]  rst_n, cyc, stb, we;
    logic [31:0] adr   [3];
    logic [7:0]  dat_w [3];
    logic [2:0]  ack_w, stall_w;
    logic [7:0]  dat_r_w [3];
    svc_state_e  st0, st1, st2;

    spu32_wb8_pipelined_ram_if b0 ();
    spu32_wb8_pipelined_ram_if b1 ();
    spu32_wb8_pipelined_ram_if b2 ();

    assign b0.cyc = cyc[0]; assign b0.stb = stb[0]; assign b0.we = we[0];
    assign b0.adr = adr[0]; assign b0.dat_w = dat_w[0];
    assign b1.cyc = cyc[1]; assign b1.stb = stb[1]; assign b1.we = we[1];
    assign b1.adr = adr[1]; assign b1.dat_w = dat_w[1];
    assign b2.cyc = cyc[2]; assign b2.stb = stb[2]; assign b2.we = we[2];
    assign b2.adr = adr[2]; assign b2.dat_w = dat_w[2];
    assign ack_w   = {b2.ack, b1.ack, b0.ack};
    assign stall_w = {b2.stall, b1.stall, b0.stall};
    assign dat_r_w[0] = b0.dat_r;
    assign dat_r_w[1] = b1.dat_r;
    assign dat_r_w[2] = b2.dat_r;

    spu32_wb8_pipelined_ram #(.ADDR_WIDTH(12), .WAIT_STATES(0), .QUEUE_DEPTH(4)) dut0 (
        .CLK_I(clk), .RST_I(rst_n[0]), .bus(b0), .state_o(st0));
    spu32_wb8_pipelined_ram #(.ADDR_WIDTH(12), .WAIT_STATES(2), .QUEUE_DEPTH(4)) dut1 (
        .CLK_I(clk), .RST_I(rst_n[1]), .bus(b1), .state_o(st1));
    spu32_wb8_pipelined_ram #(.ADDR_WIDTH(12), .WAIT_STATES(3), .QUEUE_DEPTH(4)) dut2 (
        .CLK_I(clk), .RST_I(rst_n[2]), .bus(b2), .state_o(st2));

    // Scoreboard: {is_read, data} and the cycle the ACK is due.
    logic [8:0] exp_q [$];
    int         exp_t_q [$];
    int         act = 0;
    int         last_t = -100;
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_ack = 0;

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 2 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor_loop();
        logic [8:0] e;
        int         t;
        forever begin
            @(negedge clk);
            if (ack_w[act]) begin
                n_ack++;
                check("ack_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    t = exp_t_q.pop_front();
                    check("ack_cycle", cyc_cnt, t);
                    if (e[8]) check("rd_data", 32'(dat_r_w[act]), 32'(e[7:0]));
                end
            end
        end
    endtask

    // Drive one request from a negedge; returns at the negedge after it is accepted.
    task automatic issue(input int d, input bit w, input logic [31:0] a, input logic [7:0] v,
                         output int stalls);
        int e, t;
        stalls = 0;
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dat_w[d] = w ? v : 8'h5A;
        while (stall_w[d] && stalls < 100) begin
            @(negedge clk);
            stalls++;
        end
        check("accept_bound", 32'(stalls < 100), 1);
        e = cyc_cnt + 1;
        t = e + 1 + ws_of(d);
        if (last_t + ws_of(d) + 1 > t) t = last_t + ws_of(d) + 1;
        last_t = t;
        exp_q.push_back({~w, v});
        exp_t_q.push_back(t);
        @(negedge clk);
    endtask

    task automatic idle(input int d);
        stb[d] = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 200; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check(tag, exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    int s, stall_sum, first_stall, n0;
    logic [7:0] burst_w [4];

    initial begin
        rst_n = 3'b000; cyc = 3'b000; stb = 3'b000; we = 3'b000;
        for (int i = 0; i < 3; i++) begin
            adr[i] = '0;
            dat_w[i] = '0;
        end
        burst_w[0] = 8'h78; burst_w[1] = 8'h56; burst_w[2] = 8'h34; burst_w[3] = 8'h12;
        fork monitor_loop(); join_none

        // Reset state
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_stall", 32'(stall_w[d]), 1);
            check("rst_ack", 32'(ack_w[d]), 0);
            check("rst_dat", 32'(dat_r_w[d]), 0);
        end
        rst_n = 3'b111;
        @(negedge clk);
        for (int d = 0; d < 3; d++) check("post_rst_stall", 32'(stall_w[d]), 0);

        // Single write then read, WAIT_STATES=2
        act = 1; last_t = -100;
        issue(1, 1'b1, 32'h010, 8'hA5, s); idle(1); drain("t1_wr_drain");
        issue(1, 1'b0, 32'h010, 8'hA5, s); idle(1); drain("t1_rd_drain");
        issue(1, 1'b1, 32'h011, 8'h66, s); idle(1); drain("t1_wr2_drain");
        check("t1_dat_hold", 32'(dat_r_w[1]), 32'hA5);

        // Word burst, WAIT_STATES=0
        act = 0; last_t = -100; stall_sum = 0;
        for (int i = 0; i < 4; i++) begin
            issue(0, 1'b1, 32'h100 + i, burst_w[i], s);
            stall_sum += s;
        end
        for (int i = 0; i < 4; i++) begin
            issue(0, 1'b0, 32'h100 + i, burst_w[i], s);
            stall_sum += s;
        end
        idle(0); drain("t2_drain");
        check("t2_no_stall", stall_sum, 0);

        // Back-pressure, WAIT_STATES=3, depth 4
        act = 2; last_t = -100; first_stall = -1; n0 = n_ack;
        for (int i = 0; i < 8; i++) begin
            issue(2, 1'b1, 32'h300 + i, 8'(8'hC0 + i), s);
            if (s != 0 && first_stall < 0) first_stall = i;
        end
        idle(2); drain("t3_drain");
        check("t3_first_stall_idx", first_stall, 4);
        check("t3_ack_count", n_ack - n0, 8);
        for (int i = 0; i < 8; i++) issue(2, 1'b0, 32'h300 + i, 8'(8'hC0 + i), s);
        idle(2); drain("t3_rd_drain");

        // Abort after the first ACK, WAIT_STATES=2
        act = 1; last_t = -100;
        for (int i = 0; i < 4; i++) issue(1, 1'b1, 32'h200 + i, 8'h00, s);
        idle(1); drain("t4_pre_drain");
        for (int i = 0; i < 4; i++) issue(1, 1'b1, 32'h200 + i, 8'(8'h11 * (i + 1)), s);
        idle(1);
        n0 = n_ack;
        for (int k = 0; k < 50; k++) begin
            if (exp_q.size() <= 3) break;
            @(negedge clk);
        end
        check("t4_first_ack_seen", exp_q.size(), 3);
        cyc[1] = 1'b0;
        exp_q.delete(); exp_t_q.delete();
        repeat (12) @(negedge clk);
        check("t4_acks_after_abort", n_ack - n0, 1);
        last_t = -100;
        issue(1, 1'b0, 32'h200, 8'h11, s);
        for (int i = 1; i < 4; i++) issue(1, 1'b0, 32'h200 + i, 8'h00, s);
        idle(1); drain("t4_rd_drain");

        // Reset with 3 entries pending
        last_t = -100;
        for (int i = 0; i < 3; i++) issue(1, 1'b1, 32'h400 + i, 8'hEE, s);
        idle(1);
        rst_n[1] = 1'b0;
        #1;
        check("t5_stall_in_rst", 32'(stall_w[1]), 1);
        @(negedge clk);
        check("t5_ack_in_rst", 32'(ack_w[1]), 0);
        check("t5_stall_in_rst2", 32'(stall_w[1]), 1);
        exp_q.delete(); exp_t_q.delete();
        rst_n[1] = 1'b1;
        @(negedge clk);
        check("t5_stall_after", 32'(stall_w[1]), 0);
        check("t5_ack_after", 32'(ack_w[1]), 0);
        last_t = -100;
        issue(1, 1'b0, 32'h010, 8'hA5, s); idle(1); drain("t5_rd_drain");

        // Aliasing of upper address bits
        last_t = -100;
        issue(1, 1'b1, 32'h0000_1005, 8'h3C, s); idle(1); drain("t6_wr_drain");
        issue(1, 1'b0, 32'h0000_0005, 8'h3C, s);
        issue(1, 1'b0, 32'hFFFF_F005, 8'h3C, s);
        idle(1); drain("t6_rd_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
